// File: rtl/systolic_mac_row_if.sv
// Sample stream and accumulator result bundle for systolic_mac_row.
interface systolic_mac_row_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 32
);
    logic              in_valid;
    logic              in_first;
    logic              in_last;
    logic [DW-1:0]     b;
    logic [N*DW-1:0]   a;
    logic [N*AW-1:0]   c;
    logic [N-1:0]      c_done;

    // Producer side: drives samples, observes accumulators.
    modport master (
        output in_valid, in_first, in_last, b, a,
        input  c, c_done
    );

    // Row side: consumes samples, drives accumulators.
    modport slave (
        input  in_valid, in_first, in_last, b, a,
        output c, c_done
    );
endinterface

// File: rtl/systolic_mac_row.sv
// 1xN output-stationary systolic MAC row: B and framing ripple PE to PE,
// each PE multiplies its own A lane and accumulates with optional saturation.
module systolic_mac_row #(
    parameter int unsigned N      = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 32,
    parameter bit          SIGNED = 1'b1,
    parameter bit          SAT    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_mac_row_if.slave  bus
);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned PD = (N > 1) ? N - 1 : 1;

    typedef struct packed {
        logic          valid;
        logic          first;
        logic          last;
        logic [DW-1:0] b;
    } stage_t;

    stage_t pipe_q [PD];
    stage_t stg    [N];

    // Stage view per PE: PE0 sees the live inputs, PE i sees register i-1.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            stg[i] = '0;
        end
        stg[0].valid = bus.in_valid;
        stg[0].first = bus.in_first;
        stg[0].last  = bus.in_last;
        stg[0].b     = bus.b;
        for (int unsigned i = 1; i < N; i++) begin
            stg[i] = pipe_q[i-1];
        end
    end

    // Forwarding chain; shifts every cycle so bubbles travel as valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PD; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i + 1 < N; i++) begin
                pipe_q[i] <= stg[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pe
        logic [DW-1:0] a_lane;
        logic [PW-1:0] a_x;
        logic [PW-1:0] b_x;
        logic [PW-1:0] prod;
        logic [AW-1:0] prod_ext;
        logic [AW-1:0] base;
        logic [AW:0]   sum;
        logic [AW-1:0] acc_d;
        logic [AW-1:0] acc_q;
        logic          done_q;

        assign a_lane = bus.a[g*DW +: DW];

        // Full-width product, extension to AW and (saturating) accumulate.
        always_comb begin
            a_x      = '0;
            b_x      = '0;
            prod_ext = '0;
            sum      = '0;
            acc_d    = '0;
            if (SIGNED) begin
                a_x = PW'($signed(a_lane));
                b_x = PW'($signed(stg[g].b));
            end else begin
                a_x = PW'(a_lane);
                b_x = PW'(stg[g].b);
            end
            prod = a_x * b_x;
            if (SIGNED) begin
                prod_ext = AW'($signed(prod));
            end else begin
                prod_ext = AW'(prod);
            end
            base = stg[g].first ? '0 : acc_q;
            if (SIGNED) begin
                sum   = {base[AW-1], base} + {prod_ext[AW-1], prod_ext};
                acc_d = sum[AW-1:0];
                if (SAT && (sum[AW] != sum[AW-1])) begin
                    acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                end
            end else begin
                sum   = {1'b0, base} + {1'b0, prod_ext};
                acc_d = sum[AW-1:0];
                if (SAT && sum[AW]) begin
                    acc_d = '1;
                end
            end
        end

        // Accumulator holds on bubbles; done strobes after a last sample.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q  <= '0;
                done_q <= 1'b0;
            end else begin
                done_q <= stg[g].valid & stg[g].last;
                if (stg[g].valid) begin
                    acc_q <= acc_d;
                end
            end
        end

        assign bus.c[g*AW +: AW] = acc_q;
        assign bus.c_done[g]     = done_q;
    end
endmodule
